program_encoder: RTL and testbench

//  Encoder side of the nic8 8-bit instruction format: {bit7, dest[2:0], bit3, source[2:0]}.

---
 rtl/nic8_isa_pkg.sv | 44 ++++
 rtl/program_encoder_if.sv | 31 +++
 rtl/nic8_op_pack.sv | 21 ++
 rtl/program_encoder.sv | 147 ++++++++++++++
 tb/tb_program_encoder.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/nic8_isa_pkg.sv
`default_nettype none
// ============================================================================
// Module  : nic8_isa_pkg
// Brief   : nic8 instruction-field encodings, encoder FSM states, op packer.
// Revision: 1.0 - initial release
// ============================================================================
package nic8_isa_pkg;

    localparam int OPCODE_W = 8;

    localparam logic [2:0] DEST_IR  = 3'd0;
    localparam logic [2:0] DEST_PC  = 3'd1;
    localparam logic [2:0] DEST_A   = 3'd2;
    localparam logic [2:0] DEST_B   = 3'd3;
    localparam logic [2:0] DEST_X   = 3'd4;
    localparam logic [2:0] DEST_MEM = 3'd5;
    localparam logic [2:0] DEST_Q   = 3'd6;
    localparam logic [2:0] DEST_QHI = 3'd7;

    localparam logic [2:0] SRC_ROM  = 3'd0;
    localparam logic [2:0] SRC_ZERO = 3'd1;
    localparam logic [2:0] SRC_A    = 3'd2;
    localparam logic [2:0] SRC_B    = 3'd3;
    localparam logic [2:0] SRC_X    = 3'd4;
    localparam logic [2:0] SRC_RAM  = 3'd5;
    localparam logic [2:0] SRC_ALU  = 3'd6;
    localparam logic [2:0] SRC_S    = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OP   = 2'd1,
        ST_IMM  = 2'd2
    } encState_t;

    // Fields are packed verbatim; bit7 is kept even for non-PC destinations.
    function automatic logic [OPCODE_W-1:0] pack_op(input logic       bit7,
                                                    input logic [2:0] dest,
                                                    input logic       bit3,
                                                    input logic [2:0] source);
        return {bit7, dest, bit3, source};
    endfunction

endpackage
`default_nettype wire

// File: rtl/program_encoder_if.sv
`default_nettype none
// ============================================================================
// Module  : program_encoder_if
// Brief   : Op request channel plus program-memory write port of the encoder.
// Revision: 1.0 - initial release
// ============================================================================
interface program_encoder_if #(
    parameter int ADDR_W = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        in_dest;
    logic [2:0]        in_source;
    logic              in_bit3;
    logic              in_bit7;
    logic [7:0]        in_imm;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;

    modport master (
        output in_valid, in_dest, in_source, in_bit3, in_bit7, in_imm,
        input  in_ready, wr_en, wr_addr, wr_data
    );

    modport slave (
        input  in_valid, in_dest, in_source, in_bit3, in_bit7, in_imm,
        output in_ready, wr_en, wr_addr, wr_data
    );
endinterface
`default_nettype wire

// File: rtl/nic8_op_pack.sv
`default_nettype none
// ============================================================================
// Module  : nic8_op_pack
// Brief   : Combinational opcode packer with destination legality check.
// Revision: 1.0 - initial release
// ============================================================================
module nic8_op_pack
    import nic8_isa_pkg::*;
(
    input  wire logic                i_bit7,
    input  wire logic [2:0]          i_dest,
    input  wire logic                i_bit3,
    input  wire logic [2:0]          i_source,
    output logic      [OPCODE_W-1:0] o_opcode,
    output logic                     o_legal
);
    assign o_opcode = pack_op(i_bit7, i_dest, i_bit3, i_source);
    // Qhi has no hardware behind it.
    assign o_legal  = (i_dest != DEST_QHI);
endmodule
`default_nettype wire

// File: rtl/program_encoder.sv
`default_nettype none
// ============================================================================
// Module  : program_encoder
// Brief   : Packs symbolic nic8 ops into opcode (+ immediate) bytes and writes
//           them sequentially into program memory.
// Revision: 1.0 - initial release
// ============================================================================
module program_encoder
    import nic8_isa_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  wire logic          clk,
    input  wire logic          resetBar,
    input  wire logic          clear,
    program_encoder_if.slave   bus,
    output logic [ADDR_W:0]    count,
    output logic               full,
    output logic               err
);
    localparam logic [ADDR_W:0] c_DEPTH = (ADDR_W+1)'(DEPTH);

    encState_t         r_state, w_stateNext;
    logic [ADDR_W-1:0] r_addr, w_addrNext;
    logic [ADDR_W:0]   r_count, w_countNext;
    logic              r_full, w_fullNext;
    logic              r_err, w_errNext;
    logic              r_ready, w_readyNext;
    logic              r_wrEn, w_wrEnNext;
    logic [ADDR_W-1:0] r_wrAddr, w_wrAddrNext;
    logic [7:0]        r_wrData, w_wrDataNext;
    logic [7:0]        r_imm, w_immNext;
    logic              r_hasImm, w_hasImmNext;

    logic [OPCODE_W-1:0] w_opcode;
    logic                w_legal;
    logic [ADDR_W:0]     w_countInc;

    nic8_op_pack u_pack (
        .i_bit7   (bus.in_bit7),
        .i_dest   (bus.in_dest),
        .i_bit3   (bus.in_bit3),
        .i_source (bus.in_source),
        .o_opcode (w_opcode),
        .o_legal  (w_legal)
    );

    assign w_countInc = r_count + (ADDR_W+1)'(1);

    always_ff @(posedge clk or negedge resetBar) begin
        if (!resetBar) begin
            r_state  <= ST_IDLE;
            r_addr   <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_err    <= 1'b0;
            r_ready  <= 1'b0;
            r_wrEn   <= 1'b0;
            r_wrAddr <= '0;
            r_wrData <= '0;
            r_imm    <= '0;
            r_hasImm <= 1'b0;
        end else begin
            r_state  <= w_stateNext;
            r_addr   <= w_addrNext;
            r_count  <= w_countNext;
            r_full   <= w_fullNext;
            r_err    <= w_errNext;
            r_ready  <= w_readyNext;
            r_wrEn   <= w_wrEnNext;
            r_wrAddr <= w_wrAddrNext;
            r_wrData <= w_wrDataNext;
            r_imm    <= w_immNext;
            r_hasImm <= w_hasImmNext;
        end
    end

    // Write strobes and data are registered from the next state, so the
    // byte belonging to state OP/IMM is on the port during that state.
    always_comb begin
        w_stateNext  = r_state;
        w_addrNext   = r_addr;
        w_countNext  = r_count;
        w_fullNext   = r_full;
        w_errNext    = r_err;
        w_wrEnNext   = 1'b0;
        w_wrAddrNext = r_wrAddr;
        w_wrDataNext = r_wrData;
        w_immNext    = r_imm;
        w_hasImmNext = r_hasImm;

        if (clear) begin
            w_stateNext  = ST_IDLE;
            w_addrNext   = '0;
            w_countNext  = '0;
            w_fullNext   = 1'b0;
            w_errNext    = 1'b0;
            w_wrAddrNext = '0;
            w_wrDataNext = '0;
            w_immNext    = '0;
            w_hasImmNext = 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.in_valid && r_ready) begin
                        if (w_legal) begin
                            w_stateNext  = ST_OP;
                            w_wrEnNext   = 1'b1;
                            w_wrAddrNext = r_addr;
                            w_wrDataNext = w_opcode;
                            w_immNext    = bus.in_imm;
                            w_hasImmNext = (bus.in_source == SRC_ROM);
                        end else begin
                            w_errNext = 1'b1;
                        end
                    end
                end
                ST_OP, ST_IMM: begin
                    w_addrNext  = r_addr + ADDR_W'(1);
                    w_countNext = w_countInc;
                    w_fullNext  = (c_DEPTH - w_countInc) < (ADDR_W+1)'(2);
                    if (r_state == ST_OP && r_hasImm) begin
                        w_stateNext  = ST_IMM;
                        w_wrEnNext   = 1'b1;
                        w_wrAddrNext = r_addr + ADDR_W'(1);
                        w_wrDataNext = r_imm;
                    end else begin
                        w_stateNext = ST_IDLE;
                    end
                end
                default: w_stateNext = ST_IDLE;
            endcase
        end
        w_readyNext = (w_stateNext == ST_IDLE) && !w_fullNext && !clear;
    end

    // clear suppresses any write already scheduled for this cycle.
    assign bus.wr_en    = r_wrEn & ~clear;
    assign bus.wr_addr  = r_wrAddr;
    assign bus.wr_data  = r_wrData;
    assign bus.in_ready = r_ready;
    assign count        = r_count;
    assign full         = r_full;
    assign err          = r_err;
endmodule
`default_nettype wire

// File: tb/tb_program_encoder.sv
`default_nettype none
// ============================================================================
// Module  : tb_program_encoder
// Brief   : Directed bench for program_encoder with a write scoreboard.
// Revision: 1.0 - initial release
// ============================================================================
module tb_program_encoder;
    localparam int ADDR_W = 4;
    localparam int DEPTH  = 4;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [7:0]        data;
    } wrExp_t;

    logic            clk = 1'b0;
    logic            resetBar;
    logic            clear;
    logic [ADDR_W:0] count;
    logic            full;
    logic            err;

    int     checks   = 0;
    int     failures = 0;
    wrExp_t expQ[$];
    int     expAddr  = 0;

    program_encoder_if #(.ADDR_W(ADDR_W)) bus ();

    program_encoder #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .resetBar (resetBar),
        .clear    (clear),
        .bus      (bus),
        .count    (count),
        .full     (full),
        .err      (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every write on the port must match the oldest expectation.
    always @(negedge clk) begin
        if (bus.wr_en === 1'b1) begin
            if (expQ.size() == 0) begin
                check("unexpected_write", {8'h00, bus.wr_data}, 16'hDEAD);
            end else begin
                wrExp_t e;
                e = expQ.pop_front();
                check("wr_addr", 16'(bus.wr_addr), 16'(e.addr));
                check("wr_data", 16'(bus.wr_data), 16'(e.data));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic waitReady();
        int n = 0;
        while (bus.in_ready !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        if (bus.in_ready !== 1'b1) check("ready_timeout", 16'(bus.in_ready), 16'h1);
    endtask

    task automatic drive(input logic [2:0] dest, input logic [2:0] src,
                         input logic b3, input logic b7, input logic [7:0] imm);
        bus.in_dest   = dest;
        bus.in_source = src;
        bus.in_bit3   = b3;
        bus.in_bit7   = b7;
        bus.in_imm    = imm;
        bus.in_valid  = 1'b1;
    endtask

    task automatic pushExp(input logic [7:0] data);
        wrExp_t e;
        e.addr = ADDR_W'(expAddr);
        e.data = data;
        expQ.push_back(e);
        expAddr++;
    endtask

    // Returns one cycle after the accepting edge (the OP cycle).
    task automatic sendOp(input logic [2:0] dest, input logic [2:0] src,
                          input logic b3, input logic b7, input logic [7:0] imm,
                          input logic legal, input logic [7:0] expOp);
        drive(dest, src, b3, b7, imm);
        waitReady();
        if (legal) begin
            pushExp(expOp);
            if (src == 3'd0) pushExp(imm);
        end
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic doClear();
        clear = 1'b1;
        tick();
        clear   = 1'b0;
        expAddr = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        resetBar     = 1'b0;
        clear        = 1'b0;
        bus.in_valid = 1'b0;
        drive(3'd0, 3'd0, 1'b0, 1'b0, 8'h00);
        bus.in_valid = 1'b0;
        tick();
        tick();
        check("rst_ready", 16'(bus.in_ready), 16'h0);
        check("rst_wren",  16'(bus.wr_en), 16'h0);
        check("rst_addr",  16'(bus.wr_addr), 16'h0);
        check("rst_data",  16'(bus.wr_data), 16'h0);
        check("rst_count", 16'(count), 16'h0);
        check("rst_full",  16'(full), 16'h0);
        check("rst_err",   16'(err), 16'h0);
        resetBar = 1'b1;
        tick();
        check("ready_after_rst", 16'(bus.in_ready), 16'h1);

        // A <- X
        sendOp(3'd2, 3'd4, 1'b0, 1'b0, 8'h00, 1'b1, 8'h24);
        check("t1_wren_n1", 16'(bus.wr_en), 16'h1);
        tick();
        check("t1_count", 16'(count), 16'h1);

        // Immediate load A <- 0x5A
        doClear();
        check("t2_count_clr", 16'(count), 16'h0);
        sendOp(3'd2, 3'd0, 1'b0, 1'b0, 8'h5A, 1'b1, 8'h20);
        check("t2_ready_op", 16'(bus.in_ready), 16'h0);
        tick();
        check("t2_ready_imm", 16'(bus.in_ready), 16'h0);
        check("t2_wren_imm",  16'(bus.wr_en), 16'h1);
        tick();
        check("t2_wren_done", 16'(bus.wr_en), 16'h0);
        check("t2_ready_end", 16'(bus.in_ready), 16'h1);
        check("t2_count",     16'(count), 16'h2);

        // Conditional jump, then ALU subtract
        doClear();
        sendOp(3'd1, 3'd0, 1'b1, 1'b1, 8'h10, 1'b1, 8'h98);
        sendOp(3'd3, 3'd6, 1'b1, 1'b0, 8'h00, 1'b1, 8'h3E);
        tick();
        check("t3_count", 16'(count), 16'h3);
        check("t3_full",  16'(full), 16'h1);

        // Illegal Qhi destination
        doClear();
        sendOp(3'd7, 3'd2, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
        check("t4_err",   16'(err), 16'h1);
        check("t4_wren",  16'(bus.wr_en), 16'h0);
        check("t4_count", 16'(count), 16'h0);
        sendOp(3'd2, 3'd3, 1'b0, 1'b0, 8'h00, 1'b1, 8'h23);
        tick();
        check("t4_err_sticky", 16'(err), 16'h1);
        check("t4_count2",     16'(count), 16'h1);

        // Fill a 4-slot memory
        doClear();
        check("t5_err_clr",  16'(err), 16'h0);
        check("t5_full_clr", 16'(full), 16'h0);
        sendOp(3'd2, 3'd4, 1'b0, 1'b0, 8'h00, 1'b1, 8'h24);
        sendOp(3'd3, 3'd2, 1'b0, 1'b0, 8'h00, 1'b1, 8'h32);
        sendOp(3'd4, 3'd5, 1'b0, 1'b0, 8'h00, 1'b1, 8'h45);
        tick();
        check("t5_full",  16'(full), 16'h1);
        check("t5_count", 16'(count), 16'h3);
        drive(3'd2, 3'd1, 1'b0, 1'b0, 8'h00);
        repeat (3) tick();
        check("t5_ready_full", 16'(bus.in_ready), 16'h0);
        check("t5_count_held", 16'(count), 16'h3);
        doClear();
        bus.in_valid = 1'b0;
        check("t5_count_clr2", 16'(count), 16'h0);
        check("t5_full_clr2",  16'(full), 16'h0);
        sendOp(3'd4, 3'd3, 1'b0, 1'b0, 8'h00, 1'b1, 8'h43);
        tick();

        // clear during the OP cycle of an immediate op
        doClear();
        drive(3'd2, 3'd0, 1'b0, 1'b0, 8'h77);
        waitReady();
        tick();
        bus.in_valid = 1'b0;
        clear = 1'b1;
        #1;
        check("t6_clear_wren", 16'(bus.wr_en), 16'h0);
        tick();
        clear   = 1'b0;
        expAddr = 0;
        check("t6_wren_after", 16'(bus.wr_en), 16'h0);
        check("t6_addr",       16'(bus.wr_addr), 16'h0);
        check("t6_count",      16'(count), 16'h0);
        check("t6_ready_clr",  16'(bus.in_ready), 16'h0);
        tick();
        check("t6_ready_rise", 16'(bus.in_ready), 16'h1);

        // async reset during the IMM write
        sendOp(3'd2, 3'd0, 1'b0, 1'b0, 8'h66, 1'b0, 8'h00);
        pushExp(8'h20);
        tick();
        check("t6_imm_wren", 16'(bus.wr_en), 16'h1);
        resetBar = 1'b0;
        #1;
        check("t6_rst_wren",  16'(bus.wr_en), 16'h0);
        check("t6_rst_count", 16'(count), 16'h0);
        tick();
        resetBar = 1'b1;
        expAddr  = 0;
        tick();
        check("t6_rst_ready", 16'(bus.in_ready), 16'h1);

        tick();
        check("sb_empty", 16'(expQ.size()), 16'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
